// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for every pipeline-stage register instance.
// Holds the control-field widths, the packed control bundle with its
// bubble value, and a small helper that counts held entries.
package pipe_pkg;

   localparam int WBSEL_W  = 2;
   localparam int ALUSEL_W = 4;
   localparam int RSEL_W   = 3;
   localparam int WSEL_W   = 2;
   localparam int OPC_W    = 5;

   typedef struct packed {
      logic [WBSEL_W-1:0]  wbsel;
      logic                memrw;
      logic [ALUSEL_W-1:0] alusel;
      logic                asel;
      logic                bsel;
      logic [RSEL_W-1:0]   rsel;
      logic [WSEL_W-1:0]   wsel;
      logic                regwrite;
      logic [OPC_W-1:0]    opcode;
   } ctrl_t;

   localparam int    CTRL_BUNDLE_W = $bits(ctrl_t);
   // Bubble pattern: no register write, no memory access.
   localparam ctrl_t PIPE_CTRL_NOP = '0;

   // Number of valid slots, 0..2.
   function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// master = the side that produces into and drains from the stage,
// slave  = the stage register itself.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one valid+ctrl+data holding register.
// kill has priority over load; a killed slot keeps its data but shows
// the bubble control pattern.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                CTRL_W   = 16,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              kill_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

   // Next-state: kill empties the slot, otherwise load captures the source.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (kill_i) begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_NOP;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         ctrl_d  = ctrl_i;
      end
   end

   // Slot register with synchronous reset to an empty bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= CTRL_NOP;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: handshaked pipeline-stage register with flush.
// Optional macro PIPE_STAGE_SKID_EN adds a second (skid) slot so in_ready
// comes straight from a flop; without it in_ready passes out_ready through
// combinationally and only the main slot exists.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                CTRL_W   = 16,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   pipe_stage_skid_if.slave    bus,
   output logic [1:0]          occupancy
);

   logic              accept, emit, main_upd;
   logic              main_v, main_load, main_kill;
   logic [DATA_W-1:0] main_src_data;
   logic [CTRL_W-1:0] main_src_ctrl;

   assign accept        = bus.in_valid & bus.in_ready;
   assign emit          = main_v & bus.out_ready;
   assign main_upd      = ~main_v | emit;
   assign bus.out_valid = main_v;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_v, skid_load, skid_kill;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   // Ready depends only on the skid flop, never on out_ready.
   assign bus.in_ready = ~skid_v;

   // Handshake steering: the older skid entry always feeds main first.
   always_comb begin
      main_load     = main_upd & (skid_v | accept);
      main_kill     = flush | (main_upd & ~skid_v & ~accept);
      main_src_data = skid_v ? skid_data : bus.in_data;
      main_src_ctrl = skid_v ? skid_ctrl : bus.in_ctrl;
      skid_load     = accept & main_v & ~emit;
      skid_kill     = flush | (skid_v & main_upd);
   end

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (skid_load),
      .kill_i  (skid_kill),
      .data_i  (bus.in_data),
      .ctrl_i  (bus.in_ctrl),
      .valid_o (skid_v),
      .data_o  (skid_data),
      .ctrl_o  (skid_ctrl)
   );

   assign occupancy = occ_count(main_v, skid_v);
`else
   // Accept only when main is empty or draining this cycle.
   assign bus.in_ready = ~main_v | bus.out_ready;

   // Handshake steering: main loads straight from the input.
   always_comb begin
      main_load     = accept;
      main_kill     = flush | (main_upd & ~accept);
      main_src_data = bus.in_data;
      main_src_ctrl = bus.in_ctrl;
   end

   assign occupancy = occ_count(main_v, 1'b0);
`endif

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load_i  (main_load),
      .kill_i  (main_kill),
      .data_i  (main_src_data),
      .ctrl_i  (main_src_ctrl),
      .valid_o (main_v),
      .data_o  (bus.out_data),
      .ctrl_o  (bus.out_ctrl)
   );

endmodule
